// File: rtl/req_ack_arb.sv
// Round-robin arbiter merging N_SRC blocking req/ack sources onto one destination, one transaction in flight.
// Optional destination-stall timeout when REQ_ACK_ARB_TIMEOUT_EN is defined (adds the to_err port).
module req_ack_arb #(
  parameter int N_SRC          = 4,
  parameter int DATA_W         = 32,
  parameter int RDATA_W        = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDW           = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          src_req,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_ack,
  output logic [RDATA_W-1:0]        src_rdata,
  output logic                      dst_req,
  output logic [DATA_W-1:0]         dst_data,
  output logic [IDW-1:0]            dst_id,
  input  logic                      dst_ack,
  input  logic [RDATA_W-1:0]        dst_rdata
`ifdef REQ_ACK_ARB_TIMEOUT_EN
  ,output logic                     to_err
`endif
);

  if (N_SRC < 2 || N_SRC > 16) begin : g_bad_nsrc
    $error("req_ack_arb: N_SRC must be 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("req_ack_arb: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic                dst_req_q, dst_req_d;
  logic [DATA_W-1:0]   dst_data_q, dst_data_d;
  logic [IDW-1:0]      dst_id_q, dst_id_d;
  logic [N_SRC-1:0]    src_ack_q, src_ack_d;
  logic [RDATA_W-1:0]  src_rdata_q, src_rdata_d;
  logic                win_vld;
  logic [IDW-1:0]      win_id;

`ifdef REQ_ACK_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                to_err_q, to_err_d;
`endif

  // First requesting source at or after ptr, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_SRC;
      if (!win_vld && src_req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dst_req_d   = dst_req_q;
    dst_data_d  = dst_data_q;
    dst_id_d    = dst_id_q;
    src_ack_d   = '0;
    src_rdata_d = src_rdata_q;
`ifdef REQ_ACK_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          dst_req_d  = 1'b1;
          dst_data_d = src_data[int'(win_id)*DATA_W +: DATA_W];
          dst_id_d   = win_id;
          ptr_d      = (int'(win_id) == N_SRC - 1) ? '0 : win_id + 1'b1;
          state_d    = BUSY;
`ifdef REQ_ACK_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      BUSY: begin
        if (dst_ack) begin
          dst_req_d           = 1'b0;
          src_ack_d[dst_id_q] = 1'b1;
          src_rdata_d         = dst_rdata;
          state_d             = ACK;
        end
`ifdef REQ_ACK_ARB_TIMEOUT_EN
        // cnt_q counts completed BUSY cycles, so this is the last allowed one.
        else if (int'(cnt_q) == TIMEOUT_CYCLES - 1) begin
          dst_req_d           = 1'b0;
          src_ack_d[dst_id_q] = 1'b1;
          src_rdata_d         = '0;
          to_err_d            = 1'b1;
          state_d             = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      dst_req_q   <= 1'b0;
      dst_data_q  <= '0;
      dst_id_q    <= '0;
      src_ack_q   <= '0;
      src_rdata_q <= '0;
`ifdef REQ_ACK_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      to_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dst_req_q   <= dst_req_d;
      dst_data_q  <= dst_data_d;
      dst_id_q    <= dst_id_d;
      src_ack_q   <= src_ack_d;
      src_rdata_q <= src_rdata_d;
`ifdef REQ_ACK_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      to_err_q    <= to_err_d;
`endif
    end
  end

  assign src_ack   = src_ack_q;
  assign src_rdata = src_rdata_q;
  assign dst_req   = dst_req_q;
  assign dst_data  = dst_data_q;
  assign dst_id    = dst_id_q;
`ifdef REQ_ACK_ARB_TIMEOUT_EN
  assign to_err    = to_err_q;
`endif

endmodule
